// File: rtl/fir_stage_sched.sv
// fir_stage_sched: time-shares one FIR/MAC engine across a chain of decimating
// filter stages. Each stage owns a one-sample hold slot. A fixed-priority
// scheduler launches the engine on the deepest pending stage first, keeps every
// DEC-th result, and forwards it to the next stage or to the output stream.
module fir_stage_sched #(
    parameter int WIDTH    = 16,
    parameter int N_STAGES = 2,
    parameter int DEC      = 4,
    parameter int TIMEOUT  = 63
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             fir_start,
    output logic [1:0]       fir_bank,
    output logic [WIDTH-1:0] fir_data,
    input  logic             fir_done,
    input  logic [WIDTH-1:0] fir_result,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    input  logic             clr_status,
    output logic             overrun,
    output logic             timeout_err
);

    localparam int SEL_W  = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam int DCNT_W = (DEC > 1) ? $clog2(DEC) : 1;
    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    localparam logic [SEL_W-1:0]  LAST     = SEL_W'(N_STAGES - 1);
    localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEC - 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]        state;
    logic [SEL_W-1:0]  sel;
    logic [SEL_W-1:0]  grant;
    logic              any_pending;
    logic [WCNT_W-1:0] wcnt;

    logic [WIDTH-1:0]    hold [N_STAGES];
    logic [N_STAGES-1:0] pending;
    logic [DCNT_W-1:0]   dcnt [N_STAGES];

    logic slot0_free;   // stage-0 slot is being issued this cycle
    logic done_ok;      // engine result arrives while we are waiting for it
    logic keep;         // this result survives decimation
    logic timeout_hit;  // engine gave no answer within the wait budget
    logic accept0;      // new input sample takes the stage-0 slot
    logic drop0;        // new input sample finds the stage-0 slot occupied

    // Fixed-priority grant: the highest pending stage wins so results drain downstream first.
    always_comb begin
        // NOTE: defaults come first so no path leaves a variable unassigned (no inferred latch).
        any_pending = |pending;
        grant       = '0;
        for (int s = 0; s < N_STAGES; s++) begin
            if (pending[s]) grant = SEL_W'(s);
        end
    end

    assign slot0_free  = (state == ISSUE) && (sel == '0);
    assign done_ok     = (state == WAIT) && fir_done;
    assign keep        = done_ok && (dcnt[sel] == '0);
    assign timeout_hit = (state == WAIT) && !fir_done && (wcnt == WCNT_MAX);
    assign accept0     = in_valid && (!pending[0] || slot0_free);
    assign drop0       = in_valid && pending[0] && !slot0_free;

    // Engine handshake FSM: grant a stage, launch it, then wait for the result or give up.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= '0;
            wcnt      <= '0;
            busy      <= 1'b0;
            fir_start <= 1'b0;
            fir_bank  <= '0;
            fir_data  <= '0;
        end else begin
            fir_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_pending) begin
                        sel   <= grant;
                        state <= ISSUE;
                        busy  <= 1'b1;
                    end
                end
                ISSUE: begin
                    fir_start <= 1'b1;
                    fir_bank  <= 2'(sel);
                    fir_data  <= hold[sel];
                    wcnt      <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (fir_done || timeout_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Per-stage slots: input capture, forwarding of kept results and decimation counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            for (int s = 0; s < N_STAGES; s++) begin
                // NOTE: the hold slots are reset too, since their contents reach fir_data directly.
                hold[s] <= '0;
                dcnt[s] <= '0;
            end
        end else begin
            if (state == ISSUE) pending[sel] <= 1'b0;
            // Written after the issue clear so a sample arriving as slot 0 is issued still lands.
            if (accept0) begin
                hold[0]    <= in_data;
                pending[0] <= 1'b1;
            end
            for (int s = 0; s < N_STAGES - 1; s++) begin
                if (keep && (sel == SEL_W'(s))) begin
                    hold[s+1]    <= fir_result;
                    pending[s+1] <= 1'b1;
                end
            end
            // A timed-out launch never reaches here, so its counter is left alone.
            if (done_ok) begin
                dcnt[sel] <= (dcnt[sel] == DCNT_MAX) ? '0 : dcnt[sel] + 1'b1;
            end
        end
    end

    // Output stream and sticky status flags; a set event beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (keep && (sel == LAST)) begin
                out_valid <= 1'b1;
                out_data  <= fir_result;
            end
            if (drop0)           overrun <= 1'b1;
            else if (clr_status) overrun <= 1'b0;
            if (timeout_hit)     timeout_err <= 1'b1;
            else if (clr_status) timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_stage_sched.sv
// tb_fir_stage_sched: scoreboard bench. Stimulus pushes expected engine
// launches and final outputs from a stage-by-stage decimation model; a monitor
// pops and compares whenever the DUT shows fir_start or out_valid.
module tb_fir_stage_sched;

    localparam int WIDTH    = 16;
    localparam int N_STAGES = 2;
    localparam int DEC      = 4;
    localparam int TIMEOUT  = 63;

    typedef struct {
        logic [1:0]       bank;
        logic [WIDTH-1:0] data;
    } launch_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             fir_start;
    logic [1:0]       fir_bank;
    logic [WIDTH-1:0] fir_data;
    logic             fir_done;
    logic [WIDTH-1:0] fir_result;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             busy;
    logic             clr_status;
    logic             overrun;
    logic             timeout_err;

    // engine model controls and the bench-side stale-result injector
    logic             eng_done;
    logic [WIDTH-1:0] eng_res;
    logic             tb_done;
    logic [WIDTH-1:0] tb_res;
    bit               eng_mute;
    int               eng_lat;

    int n_checks;
    int n_fail;
    int cyc;
    int n_out_seen;
    int n_b1_seen;

    launch_t          exp_launch[$];
    logic [WIDTH-1:0] exp_out[$];
    int               mcnt[N_STAGES];

    assign fir_done   = eng_done | tb_done;
    assign fir_result = tb_done ? tb_res : eng_res;

    fir_stage_sched #(
        .WIDTH(WIDTH), .N_STAGES(N_STAGES), .DEC(DEC), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data),
        .fir_start(fir_start), .fir_bank(fir_bank), .fir_data(fir_data),
        .fir_done(fir_done), .fir_result(fir_result),
        .out_valid(out_valid), .out_data(out_data),
        .busy(busy), .clr_status(clr_status),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference model: one accepted sample ripples through the stages; a stage
    // keeps every DEC-th of its own results starting with the first, and the
    // engine answers data + bank.
    task automatic model_chain(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] v;
        v = x;
        for (int s = 0; s < N_STAGES; s++) begin
            bit kept;
            exp_launch.push_back('{bank: 2'(s), data: v});
            v = v + WIDTH'(s);
            kept = (mcnt[s] == 0);
            mcnt[s] = (mcnt[s] + 1) % DEC;
            if (!kept) return;
            if (s == N_STAGES - 1) exp_out.push_back(v);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < N_STAGES; s++) mcnt[s] = 0;
    endtask

    // All drivers start #1 after a rising edge; the strobe is sampled at the next edge.
    task automatic pulse_in(input logic [WIDTH-1:0] x);
        in_valid = 1'b1;
        in_data  = x;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_status = 1'b1;
        @(posedge clk);
        #1 clr_status = 1'b0;
    endtask

    task automatic inject_done(input logic [WIDTH-1:0] r);
        tb_res  = r;
        tb_done = 1'b1;
        @(posedge clk);
        #1 tb_done = 1'b0;
    endtask

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        while (busy || exp_launch.size() != 0 || exp_out.size() != 0) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 600) begin
                fail_now(name);
                return;
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_chain(input logic [WIDTH-1:0] x);
        model_chain(x);
        pulse_in(x);
        wait_quiet("drain_timeout");
    endtask

    // Push inputs until stage 0's next result will be kept.
    task automatic align_stage0();
        while (mcnt[0] != 0) send_chain(WIDTH'($urandom));
    endtask

    // Two samples 2 cycles apart while the engine is busy: the later one is dropped.
    task automatic overrun_burst(input bit with_clr, input string name);
        logic [WIDTH-1:0] a, b, c;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        c = ~b;
        eng_lat = 20;
        model_chain(a);
        model_chain(b);
        pulse_in(a);
        repeat (4) @(posedge clk);
        #1;
        pulse_in(b);
        @(posedge clk);
        #1;
        if (with_clr) clr_status = 1'b1;
        pulse_in(c);
        clr_status = 1'b0;
        check(name, overrun, 1);
        wait_quiet("overrun_drain");
    endtask

    // Engine model: answers each launch with data + bank after eng_lat cycles.
    initial begin
        logic [1:0]       eb;
        logic [WIDTH-1:0] ed;
        int               lat;
        eng_done = 1'b0;
        eng_res  = '0;
        forever begin
            @(negedge clk);
            if (fir_start && rst_n && !eng_mute) begin
                eb  = fir_bank;
                ed  = fir_data;
                lat = eng_lat;
                repeat (lat) @(posedge clk);
                #1;
                eng_done = 1'b1;
                eng_res  = ed + WIDTH'(eb);
                @(posedge clk);
                #1 eng_done = 1'b0;
            end
        end
    end

    // Monitor: every launch and every final sample must match the head of its queue.
    always @(negedge clk) begin
        launch_t          ml;
        logic [WIDTH-1:0] mo;
        if (rst_n) begin
            if (fir_start) begin
                if (fir_bank == 2'd1) n_b1_seen++;
                if (exp_launch.size() == 0) begin
                    $display("FAIL unexpected_launch: bank %0d data %0h with nothing expected", fir_bank, fir_data);
                    n_checks++;
                    n_fail++;
                end else begin
                    ml = exp_launch.pop_front();
                    check("launch_bank", fir_bank, ml.bank);
                    check("launch_data", fir_data, ml.data);
                end
            end
            if (out_valid) begin
                n_out_seen++;
                if (exp_out.size() == 0) begin
                    $display("FAIL unexpected_out: out_data %0h with nothing expected", out_data);
                    n_checks++;
                    n_fail++;
                end else begin
                    mo = exp_out.pop_front();
                    check("out_data", out_data, mo);
                end
            end
        end
    end

    initial begin
        int out0, b10, t0, t1;
        logic [WIDTH-1:0] a, b;

        n_checks   = 0;
        n_fail     = 0;
        n_out_seen = 0;
        n_b1_seen  = 0;
        cyc        = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        clr_status = 1'b0;
        tb_done    = 1'b0;
        tb_res     = '0;
        eng_mute   = 1'b0;
        eng_lat    = 5;
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_fir_start", fir_start, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // steady chain: data = k every 33 cycles, engine latency 5
        out0 = n_out_seen;
        b10  = n_b1_seen;
        for (int k = 0; k < 40; k++) begin
            model_chain(WIDTH'(k));
            pulse_in(WIDTH'(k));
            repeat (32) @(posedge clk);
            #1;
        end
        wait_quiet("steady_drain");
        check("steady_out_count", n_out_seen - out0, 3);
        check("steady_bank1_count", n_b1_seen - b10, 10);
        check("steady_out_data_hold", out_data, 33);
        check("steady_no_overrun", overrun, 0);

        // randomized data, spacing and engine latency within the sustainable rate
        for (int i = 0; i < 30; i++) begin
            logic [WIDTH-1:0] x;
            x = WIDTH'($urandom);
            eng_lat = $urandom_range(1, 8);
            model_chain(x);
            pulse_in(x);
            repeat ($urandom_range(32, 50)) @(posedge clk);
            #1;
        end
        wait_quiet("random_drain");
        check("random_no_overrun", overrun, 0);

        // async reset in WAIT with a second sample pending
        eng_mute = 1'b1;
        exp_launch.push_back('{bank: 2'd0, data: 16'h1234});
        pulse_in(16'h1234);
        repeat (3) @(posedge clk);
        #1;
        pulse_in(16'h5678);
        check("pre_reset_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_fir_start", fir_start, 0);
        check("mid_rst_fir_bank", fir_bank, 0);
        check("mid_rst_fir_data", fir_data, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_timeout_err", timeout_err, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        inject_done(16'h4321);
        check("stale_done_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("stale_done_busy", busy, 0);
        eng_mute = 1'b0;
        eng_lat  = 5;
        model_chain(16'h0abc);
        pulse_in(16'h0abc);
        @(posedge clk);
        #1;
        check("post_rst_start_early", fir_start, 0);
        @(posedge clk);
        #1;
        check("post_rst_start_latency", fir_start, 1);
        check("post_rst_start_bank", fir_bank, 0);
        wait_quiet("post_rst_drain");

        // priority: stage-1 result and a new sample pending together -> bank 1 first
        align_stage0();
        eng_lat = 10;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        model_chain(a);
        model_chain(b);
        pulse_in(a);
        repeat (3) @(posedge clk);
        #1;
        pulse_in(b);
        wait_quiet("priority_drain");

        // overrun, clear, and set-beats-clear
        overrun_burst(1'b0, "overrun_set");
        pulse_clr();
        check("overrun_cleared", overrun, 0);
        overrun_burst(1'b1, "overrun_set_beats_clear");
        pulse_clr();
        check("overrun_cleared_again", overrun, 0);

        // timeout: engine silent, late result ignored, counter untouched
        align_stage0();
        eng_lat  = 5;
        eng_mute = 1'b1;
        a = WIDTH'($urandom);
        exp_launch.push_back('{bank: 2'd0, data: a});
        pulse_in(a);
        t0 = -1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (fir_start) begin
                t0 = cyc;
                break;
            end
        end
        if (t0 < 0) fail_now("timeout_no_launch");
        t1 = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                t1 = cyc;
                break;
            end
        end
        check("timeout_busy_fall", 64'(t1 - t0), 64'(TIMEOUT + 1));
        check("timeout_err_set", timeout_err, 1);
        inject_done(16'h7777);
        check("late_done_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        check("late_done_busy", busy, 0);
        eng_mute = 1'b0;
        pulse_clr();
        check("timeout_err_cleared", timeout_err, 0);
        send_chain(WIDTH'($urandom));

        // in_valid coincident with ISSUE for bank 0 is accepted
        eng_lat = 5;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        model_chain(a);
        model_chain(b);
        pulse_in(a);
        @(posedge clk);
        #1;
        pulse_in(b);
        check("issue_coincident_no_overrun", overrun, 0);
        wait_quiet("boundary_drain");
        check("boundary_no_overrun", overrun, 0);

        wait_quiet("final_drain");
        check("launch_queue_empty", exp_launch.size(), 0);
        check("out_queue_empty", exp_out.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
